// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with reservation (pending) tracking
// Optional same-cycle write-to-read bypass enabled by defining REG_FILE_BYPASS_EN.
module reg_file_mp #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clk_enable,
   input  logic [ADDR_WIDTH-1:0] read_reg_a,
   input  logic [ADDR_WIDTH-1:0] read_reg_b,
   output logic [DATA_WIDTH-1:0] read_data_a,
   output logic [DATA_WIDTH-1:0] read_data_b,
   output logic                  read_pend_a,
   output logic                  read_pend_b,
   input  logic                  write0_enable,
   input  logic [ADDR_WIDTH-1:0] write0_reg,
   input  logic [DATA_WIDTH-1:0] write0_data,
   input  logic                  write1_enable,
   input  logic [ADDR_WIDTH-1:0] write1_reg,
   input  logic [DATA_WIDTH-1:0] write1_data,
   input  logic                  rsv_enable,
   input  logic [ADDR_WIDTH-1:0] rsv_reg,
   output logic [ADDR_WIDTH:0]   pend_count,
   output logic [DATA_WIDTH-1:0] register_v0
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0]      pend;
   logic [DEPTH-1:0]      pend_next;
   logic [ADDR_WIDTH:0]   count_next;
   logic                  upd;
   logic [ADDR_WIDTH-1:0] rd_idx [2];
   logic [DATA_WIDTH-1:0] rd_data [2];
   logic                  rd_pend [2];

   assign upd = clk_enable && !reset;

   // Reservation is applied after the write clear so a same-cycle reserve wins (new producer).
   always_comb begin
      pend_next = pend;
      if (upd) begin
         for (int r = 1; r < DEPTH; r++) begin
            if ((write0_enable && write0_reg == ADDR_WIDTH'(r)) ||
                (write1_enable && write1_reg == ADDR_WIDTH'(r)))
               pend_next[r] = 1'b0;
            if (rsv_enable && rsv_reg == ADDR_WIDTH'(r))
               pend_next[r] = 1'b1;
         end
      end
   end

   always_comb begin
      count_next = '0;
      for (int r = 0; r < DEPTH; r++)
         count_next = count_next + {{ADDR_WIDTH{1'b0}}, pend_next[r]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < DEPTH; r++)
            mem[r] <= '0;
         pend       <= '0;
         pend_count <= '0;
      end else if (clk_enable) begin
         if (write0_enable && write0_reg != '0)
            mem[write0_reg] <= write0_data;
         // Port 1 assigned last so it wins a same-index collision.
         if (write1_enable && write1_reg != '0)
            mem[write1_reg] <= write1_data;
         pend       <= pend_next;
         pend_count <= count_next;
      end
   end

   assign rd_idx[0] = read_reg_a;
   assign rd_idx[1] = read_reg_b;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_data[p] = (rd_idx[p] == '0) ? '0 : mem[rd_idx[p]];
         rd_pend[p] = (rd_idx[p] == '0) ? 1'b0 : pend[rd_idx[p]];
`ifdef REG_FILE_BYPASS_EN
         if (upd && rd_idx[p] != '0) begin
            if (write1_enable && write1_reg == rd_idx[p]) begin
               rd_data[p] = write1_data;
               rd_pend[p] = rsv_enable && rsv_reg == rd_idx[p];
            end else if (write0_enable && write0_reg == rd_idx[p]) begin
               rd_data[p] = write0_data;
               rd_pend[p] = rsv_enable && rsv_reg == rd_idx[p];
            end
         end
`endif
      end
   end

   assign read_data_a = rd_data[0];
   assign read_data_b = rd_data[1];
   assign read_pend_a = rd_pend[0];
   assign read_pend_b = rd_pend[1];
   assign register_v0 = mem[2];

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - directed self-checking bench for reg_file_mp
module tb_reg_file_mp;
   logic        clk = 1'b0;
   logic        reset;
   logic        clk_enable;
   logic [4:0]  read_reg_a, read_reg_b;
   logic [31:0] read_data_a, read_data_b;
   logic        read_pend_a, read_pend_b;
   logic        write0_enable, write1_enable, rsv_enable;
   logic [4:0]  write0_reg, write1_reg, rsv_reg;
   logic [31:0] write0_data, write1_data;
   logic [5:0]  pend_count;
   logic [31:0] register_v0;

   int n_cmp = 0;
   int n_bad = 0;

   reg_file_mp dut (
      .clk(clk), .reset(reset), .clk_enable(clk_enable),
      .read_reg_a(read_reg_a), .read_reg_b(read_reg_b),
      .read_data_a(read_data_a), .read_data_b(read_data_b),
      .read_pend_a(read_pend_a), .read_pend_b(read_pend_b),
      .write0_enable(write0_enable), .write0_reg(write0_reg), .write0_data(write0_data),
      .write1_enable(write1_enable), .write1_reg(write1_reg), .write1_data(write1_data),
      .rsv_enable(rsv_enable), .rsv_reg(rsv_reg),
      .pend_count(pend_count), .register_v0(register_v0)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      write0_enable = 1'b0; write1_enable = 1'b0; rsv_enable = 1'b0;
   endtask

   task automatic wr0(input logic [4:0] r, input logic [31:0] d);
      write0_enable = 1'b1; write0_reg = r; write0_data = d;
   endtask

   task automatic wr1(input logic [4:0] r, input logic [31:0] d);
      write1_enable = 1'b1; write1_reg = r; write1_data = d;
   endtask

   task automatic rsv(input logic [4:0] r);
      rsv_enable = 1'b1; rsv_reg = r;
   endtask

   initial begin
      reset = 1'b1; clk_enable = 1'b1;
      read_reg_a = 5'd5; read_reg_b = 5'd0;
      write0_reg = '0; write1_reg = '0; rsv_reg = '0;
      write0_data = '0; write1_data = '0;
      idle();
      step(); step();
      reset = 1'b0;
      #1;
      check("rst_data_a", read_data_a, 32'h0);
      check("rst_pend_a", {31'b0, read_pend_a}, 32'h0);
      check("rst_count", {26'b0, pend_count}, 32'h0);
      check("rst_v0", register_v0, 32'h0);

      // basic write then read on both ports
      wr0(5'd5, 32'h12345678); step(); idle();
      check("w0_r5", read_data_a, 32'h12345678);
      check("r0_b", read_data_b, 32'h0);

      // same-index collision and writes to r0
      wr0(5'd7, 32'hAAAA0000); wr1(5'd7, 32'h0000BBBB); step(); idle();
      read_reg_a = 5'd7; #1;
      check("collide_r7", read_data_a, 32'h0000BBBB);
      wr0(5'd0, 32'hFFFFFFFF); rsv(5'd0); step(); idle();
      read_reg_a = 5'd0; #1;
      check("r0_data", read_data_a, 32'h0);
      check("r0_pend", {31'b0, read_pend_a}, 32'h0);
      check("r0_rsv_count", {26'b0, pend_count}, 32'h0);

      // reservations and pending clear
      rsv(5'd3); step(); idle();
      check("rsv3_count", {26'b0, pend_count}, 32'd1);
      rsv(5'd4); step(); idle();
      check("rsv4_count", {26'b0, pend_count}, 32'd2);
      rsv(5'd3); step(); idle();
      check("rsv3_again_count", {26'b0, pend_count}, 32'd2);
      wr0(5'd3, 32'h33); step(); idle();
      read_reg_a = 5'd3; read_reg_b = 5'd4; #1;
      check("wr3_count", {26'b0, pend_count}, 32'd1);
      check("wr3_pend3", {31'b0, read_pend_a}, 32'h0);
      check("wr3_pend4", {31'b0, read_pend_b}, 32'h1);

      // reserve and write the same register together
      rsv(5'd9); wr0(5'd9, 32'h55); step(); idle();
      read_reg_a = 5'd9; #1;
      check("rw9_data", read_data_a, 32'h55);
      check("rw9_pend", {31'b0, read_pend_a}, 32'h1);
      check("rw9_count", {26'b0, pend_count}, 32'd2);

      // clk_enable low freezes everything
      clk_enable = 1'b0;
      wr1(5'd6, 32'hDEAD); wr0(5'd4, 32'h44); rsv(5'd10); step(); idle();
      clk_enable = 1'b1;
      read_reg_a = 5'd6; read_reg_b = 5'd4; #1;
      check("frz_r6", read_data_a, 32'h0);
      check("frz_pend4", {31'b0, read_pend_b}, 32'h1);
      check("frz_count", {26'b0, pend_count}, 32'd2);

      // same-cycle visibility of a write to r2
      wr1(5'd2, 32'h11); step(); idle();
      wr1(5'd2, 32'hCAFEF00D); wr0(5'd2, 32'h0BAD0BAD); read_reg_a = 5'd2; #1;
`ifdef REG_FILE_BYPASS_EN
      check("byp_r2", read_data_a, 32'hCAFEF00D);
`else
      check("nobyp_r2", read_data_a, 32'h11);
`endif
      check("v0_old", register_v0, 32'h11);
      step(); idle();
      check("v0_new", register_v0, 32'hCAFEF00D);
      check("r2_after", read_data_a, 32'hCAFEF00D);

      // pending flag visibility during a clearing write
      rsv(5'd12); step(); idle();
      check("rsv12_count", {26'b0, pend_count}, 32'd3);
      wr0(5'd12, 32'hC); read_reg_b = 5'd12; #1;
`ifdef REG_FILE_BYPASS_EN
      check("byp_pend12", {31'b0, read_pend_b}, 32'h0);
`else
      check("nobyp_pend12", {31'b0, read_pend_b}, 32'h1);
`endif
      step(); idle();
      check("clr_pend12", {31'b0, read_pend_b}, 32'h0);
      check("clr12_count", {26'b0, pend_count}, 32'd2);

      // populate, then reset with clk_enable low and concurrent activity
      wr0(5'd1, 32'h1); wr1(5'd3, 32'h3); step(); idle();
      rsv(5'd20); step(); rsv(5'd21); step(); rsv(5'd22); step(); idle();
      check("pre_rst_count", {26'b0, pend_count}, 32'd5);
      reset = 1'b1; clk_enable = 1'b0;
      wr0(5'd1, 32'h1); rsv(5'd23); step(); idle();
      reset = 1'b0; clk_enable = 1'b1;
      read_reg_a = 5'd1; read_reg_b = 5'd20; #1;
      check("rst2_r1", read_data_a, 32'h0);
      check("rst2_pend20", {31'b0, read_pend_b}, 32'h0);
      check("rst2_count", {26'b0, pend_count}, 32'h0);
      check("rst2_v0", register_v0, 32'h0);
      read_reg_a = 5'd5; read_reg_b = 5'd3; #1;
      check("rst2_r5", read_data_a, 32'h0);
      check("rst2_r3", read_data_b, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 DATA_WIDTH, 32, bits per register.
REQ-002 ADDR_WIDTH, 5, register index bits; depth = 2**ADDR_WIDTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 clk_enable  input  1  global update enable; 0 freezes registers, pending bits, pend_count.
REQ-006 read_reg_a, read_reg_b  input  ADDR_WIDTH  read port indices.
REQ-007 read_data_a, read_data_b  output  DATA_WIDTH  read port data.
REQ-008 read_pend_a, read_pend_b  output  1  pending (reserved, not yet written) flag of the addressed register.
REQ-009 write0_enable, write0_reg, write0_data  input  1/ADDR_WIDTH/DATA_WIDTH  write port 0.
REQ-010 write1_enable, write1_reg, write1_data  input  1/ADDR_WIDTH/DATA_WIDTH  write port 1 (higher priority).
REQ-011 rsv_enable, rsv_reg  input  1/ADDR_WIDTH  reservation port; marks a register as awaiting a write.
REQ-012 pend_count  output  ADDR_WIDTH+1  number of registers currently pending (registered).
REQ-013 register_v0  output  DATA_WIDTH  stored contents of register 2, no bypass.

Function
REQ-014 Reads SHALL be combinational, zero latency, any index, both ports independent.
REQ-015 Register 0 SHALL always read 0 with read_pend 0; writes and reservations to index 0 SHALL be ignored.
REQ-016 Write port N SHALL update its register on a rising edge when writeN_enable=1, clk_enable=1, reset=0.
REQ-017 Both ports writing the same index in one cycle: register SHALL take write1_data.
REQ-018 Pending bit of register r SHALL be set on an edge with rsv_enable=1, rsv_reg=r, clk_enable=1, reset=0.
REQ-019 Pending bit of r SHALL be cleared on an edge with an enabled write to r on either port.
REQ-020 Reservation and write to the same r in one cycle: data SHALL be written and pending SHALL end at 1 (new producer).
REQ-021 Reserving an already-pending register SHALL leave it pending and SHALL NOT change pend_count.
REQ-022 pend_count SHALL equal the population count of pending bits after every edge; range 0..2**ADDR_WIDTH-1, no wrap.
REQ-023 Writing a non-pending register SHALL be legal and SHALL NOT alter pend_count.
REQ-024 With clk_enable=0 all write and reservation inputs SHALL be ignored; outputs SHALL hold.
REQ-025 register_v0 SHALL reflect the stored value of register 2 only (one cycle after a write).

Reset
REQ-026 Edge with reset=1 SHALL clear all registers, all pending bits and pend_count to 0, regardless of clk_enable.
REQ-027 reset SHALL override same-cycle writes and reservations; none take effect.
REQ-028 After reset: read_data_a/b=0, read_pend_a/b=0, pend_count=0, register_v0=0.

Configuration
REQ-029 Macro REG_FILE_BYPASS_EN defined: when an enabled write (clk_enable=1, reset=0) targets a nonzero read index, read_data SHALL return that write data in the same cycle (write1 over write0) and read_pend SHALL read 0 unless a same-cycle reservation targets it.
REQ-030 REG_FILE_BYPASS_EN undefined: reads SHALL return stored values and stored pending bits only; new data visible the cycle after the write edge.
REQ-031 register_v0 and pend_count SHALL be unaffected by REG_FILE_BYPASS_EN.

Verification
REQ-032 Reset, then write0 r5=0x12345678; next cycle read_reg_a=5 -> read_data_a=0x12345678; read_reg_b=0 -> 0.
REQ-033 Same cycle write0 r7=0xAAAA0000, write1 r7=0x0000BBBB -> next cycle r7=0x0000BBBB; write r0=0xFFFFFFFF -> r0 reads 0.
REQ-034 Reserve r3, r4, r3 on successive cycles -> pend_count 1,2,2; write r3 -> pend_count 1, read_pend for r3=0, r4=1.
REQ-035 Reserve r9 and write0 r9=0x55 same cycle -> r9=0x55, read_pend=1, pend_count +1.
REQ-036 With REG_FILE_BYPASS_EN: write1 r2=0xCAFEF00D, read_reg_a=2 same cycle -> read_data_a=0xCAFEF00D, register_v0 old value until next cycle; without macro read_data_a old value.
REQ-037 Populate r1..r4 and 3 reservations, assert reset with clk_enable=0 and concurrent write r1=0x1 -> all reads 0, pend_count 0.
